// File: rtl/dev_bus_arbiter_pkg.sv
// Shared types and helpers for the device-bus arbiter: controller state encoding,
// default geometry and the round-robin pointer wrap.
package dev_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_ACKS = 2'd2,
    ST_HOLD = 2'd3
  } busState_t;

  localparam int DEF_DBITS = 32;
  localparam int DEF_NREQ  = 2;

  function automatic int wrapNext(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dev_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo NREQ. Returns one-hot, index and an any-request flag.
module dev_bus_arbiter_rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pickOneHot,
  output logic [PW-1:0]   pickIdx,
  output logic            pickAny
);

  always_comb begin
    pickOneHot = '0;
    pickIdx    = '0;
    pickAny    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr) + k) % NREQ;
      if (!pickAny && req[idx]) begin
        pickAny         = 1'b1;
        pickOneHot[idx] = 1'b1;
        pickIdx         = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/dev_bus_arbiter.sv
// Round-robin arbiter sharing one single-beat device bus between NREQ masters, with bus lock.
// Optional DEVBUS_LOCK_TIMEOUT_EN bounds idle lock holding to LOCK_TO cycles and flags LOCK_ERR.
module dev_bus_arbiter
  import dev_bus_arbiter_pkg::*;
#(
  parameter int DBITS   = DEF_DBITS,
  parameter int NREQ    = DEF_NREQ,
  parameter int LOCK_TO = 16
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ-1:0]       LOCK,
  input  logic [NREQ-1:0]       WE_IN,
  input  logic [NREQ*DBITS-1:0] ADDR_IN,
  input  logic [NREQ*DBITS-1:0] WDATA_IN,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       ACK,
  output logic [DBITS-1:0]      RDATA,
  output logic                  LOCK_ERR,
  output logic [DBITS-1:0]      ABUS,
  inout  wire  [DBITS-1:0]      DBUS,
  output logic                  WE
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  busState_t         state, stateNext;
  logic [NREQ-1:0]   gntReg;
  logic [PW-1:0]     ownerIdx, rrPtr, latchIdx;
  logic [DBITS-1:0]  addrLat, wdataLat, rdataReg;
  logic              weLat;
  logic              latchEn, releaseBus;
  logic [NREQ-1:0]   lockEff;
  logic [NREQ-1:0]   pickOneHot;
  logic [PW-1:0]     pickIdx;
  logic              pickAny;

`ifdef DEVBUS_LOCK_TIMEOUT_EN
  localparam int CW = $clog2(LOCK_TO + 1);
  logic [CW-1:0]     holdCnt;
  logic [NREQ-1:0]   lockIgn;
  logic              lockErrReg;
  logic              timeoutHit;
`endif

  dev_bus_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) uPick (
    .req        (REQ),
    .ptr        (rrPtr),
    .pickOneHot (pickOneHot),
    .pickIdx    (pickIdx),
    .pickAny    (pickAny)
  );

  always_comb begin
    stateNext  = state;
    latchEn    = 1'b0;
    latchIdx   = ownerIdx;
    releaseBus = 1'b0;
`ifdef DEVBUS_LOCK_TIMEOUT_EN
    timeoutHit = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (pickAny) begin
          latchEn   = 1'b1;
          latchIdx  = pickIdx;
          stateNext = ST_BUS;
        end
      end
      ST_BUS:  stateNext = ST_ACKS;
      ST_ACKS: begin
        // Owner's REQ is deliberately not looked at here; only its lock decides.
        if (lockEff[ownerIdx]) begin
          stateNext = ST_HOLD;
        end else begin
          releaseBus = 1'b1;
          stateNext  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (REQ[ownerIdx]) begin
          latchEn   = 1'b1;
          stateNext = ST_BUS;
        end else if (!lockEff[ownerIdx]) begin
          releaseBus = 1'b1;
          stateNext  = ST_IDLE;
        end
`ifdef DEVBUS_LOCK_TIMEOUT_EN
        else if (holdCnt == CW'(LOCK_TO - 1)) begin
          releaseBus = 1'b1;
          timeoutHit = 1'b1;
          stateNext  = ST_IDLE;
        end
`endif
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      gntReg   <= '0;
      ownerIdx <= '0;
      rrPtr    <= '0;
      addrLat  <= '0;
      weLat    <= 1'b0;
      rdataReg <= '0;
    end else begin
      state <= stateNext;
      if (latchEn) begin
        ownerIdx <= latchIdx;
        gntReg   <= NREQ'(1) << latchIdx;
        addrLat  <= ADDR_IN[latchIdx*DBITS +: DBITS];
        weLat    <= WE_IN[latchIdx];
      end
      if (releaseBus) begin
        gntReg <= '0;
        rrPtr  <= PW'(wrapNext(int'(ownerIdx), NREQ));
      end
      if (state == ST_BUS && !weLat) begin
        rdataReg <= DBUS;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (latchEn) begin
      wdataLat <= WDATA_IN[latchIdx*DBITS +: DBITS];
    end
  end

`ifdef DEVBUS_LOCK_TIMEOUT_EN
  // A broken lock stays ignored until the master shows LOCK low once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      holdCnt    <= '0;
      lockIgn    <= '0;
      lockErrReg <= 1'b0;
    end else begin
      holdCnt    <= (state == ST_HOLD) ? holdCnt + CW'(1) : '0;
      lockErrReg <= timeoutHit;
      lockIgn    <= (lockIgn & LOCK) | (timeoutHit ? (NREQ'(1) << ownerIdx) : '0);
    end
  end

  assign lockEff  = LOCK & ~lockIgn;
  assign LOCK_ERR = lockErrReg;
`else
  assign lockEff  = LOCK;
  assign LOCK_ERR = 1'b0;
`endif

  assign GNT   = gntReg;
  assign ACK   = (state == ST_ACKS) ? gntReg : '0;
  assign WE    = (state == ST_BUS) && weLat;
  assign ABUS  = addrLat;
  assign RDATA = rdataReg;
  assign DBUS  = (state == ST_BUS && weLat) ? wdataLat : 'z;

endmodule
